// File: rtl/udp_tx_pkg.sv
// udp_tx shared package
// States, protocol constants and byte helpers
package udp_tx_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CHKSUM,
    PREAMBLE,
    ETH_HDR,
    IP_HDR,
    UDP_HDR,
    PAYLOAD,
    PAD,
    FCS,
    IFG
  } state_t;

  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam int          ETH_HDR_LEN   = 14;
  localparam int          IP_HDR_LEN    = 20;
  localparam int          UDP_HDR_LEN   = 8;
  localparam int          MIN_PAYLOAD   = 18;
  localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

  function automatic logic [31:0] bitrev32(
    input logic [31:0] v
  );
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // byte i of a left-aligned 20-byte vector
  function automatic logic [7:0] pick_byte(
    input logic [159:0] v,
    input logic [4:0]   i
  );
    logic [159:0] t;
    t = v << {i, 3'b000};
    return t[159:152];
  endfunction

endpackage

// File: rtl/udp_tx_crc32.sv
// crc32_d8: byte-wide reflected CRC-32
// Output is the complemented register value
module crc32_d8
  import udp_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  localparam logic [31:0] POLY_R = bitrev32(CRC_POLY);

  logic [31:0] c_q;
  logic [31:0] c_n;

  // LSB-first update over one byte
  always_comb begin
    c_n = c_q;
    for (int i = 0; i < 8; i++) begin
      c_n = (c_n >> 1) ^ ((c_n[0] ^ data[i]) ? POLY_R : 32'h0);
    end
  end

  // CRC register, clr wins over en
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   c_q <= CRC_INIT;
    else if (clr) c_q <= CRC_INIT;
    else if (en)  c_q <= c_n;
  end

  assign crc = ~c_q;

endmodule

// File: rtl/udp_tx.sv
// udp_tx: UDP/IPv4/Ethernet GMII frame transmitter
// Payload and FCS bytes bypass the txd register
module udp_tx
  import udp_tx_pkg::*;
#(
  parameter logic [47:0] BOARD_MAC  = 48'h00_11_22_33_44_55,
  parameter logic [47:0] DES_MAC    = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [31:0] BOARD_IP   = 32'hC0A8_010A,
  parameter logic [31:0] DES_IP     = 32'hC0A8_0166,
  parameter logic [15:0] BOARD_PORT = 16'd1234,
  parameter logic [15:0] DES_PORT   = 16'd1234,
  parameter int          IFG_CYCLES = 12
) (
  input  logic        rd_clk,
  input  logic        rst_n,
  input  logic        frame_tx_start,
  input  logic [15:0] rd_byte_num,
  input  logic [7:0]  rd_data,
  output logic        rd_en,
  output logic        frame_tx_done,
  output logic        gmii_tx_en,
  output logic [7:0]  gmii_txd
);

  state_t       state, state_n;
  logic [10:0]  cnt;
  logic [15:0]  n_q, id_q, chk_q;
  logic [31:0]  acc_q;
  logic [7:0]   byte_n, txd_q, fcs_b;
  logic         tx_en_q, rd_en_q, done_q;
  logic         pay_q, fcs_q, crc_en_q;
  logic [1:0]   fidx_q;
  logic [31:0]  crc;
  logic [15:0]  cnt16, tot_len, udp_len;
  logic [15:0]  pay_last, pad_last, fold;
  logic [159:0] eth_v, ip_v, udp_v;

  assign cnt16    = {5'b0, cnt};
  assign tot_len  = n_q + 16'd28;
  assign udp_len  = n_q + 16'd8;
  assign pay_last = n_q - 16'd1;
  assign pad_last = 16'(MIN_PAYLOAD - 1) - n_q;
  assign fold     = acc_q[31:16] + acc_q[15:0];

  assign eth_v = {DES_MAC, BOARD_MAC,
                  ETH_TYPE_IPV4, 48'h0};
  assign ip_v  = {8'h45, 8'h00, tot_len, id_q,
                  16'h4000, 8'h40, IP_PROTO_UDP,
                  chk_q, BOARD_IP, DES_IP};
  assign udp_v = {BOARD_PORT, DES_PORT, udp_len,
                  16'h0, 96'h0};

  // next state and next header byte
  always_comb begin
    state_n = state;
    byte_n  = 8'h00;
    unique case (state)
      IDLE:
        if (frame_tx_start) state_n = CHKSUM;
      CHKSUM:
        if (cnt == 11'd2) state_n = PREAMBLE;
      PREAMBLE: begin
        byte_n = (cnt == 11'd7) ? SFD_BYTE
                                : PREAMBLE_BYTE;
        if (cnt == 11'd7) state_n = ETH_HDR;
      end
      ETH_HDR: begin
        byte_n = pick_byte(eth_v, cnt[4:0]);
        if (cnt == 11'(ETH_HDR_LEN - 1))
          state_n = IP_HDR;
      end
      IP_HDR: begin
        byte_n = pick_byte(ip_v, cnt[4:0]);
        if (cnt == 11'(IP_HDR_LEN - 1))
          state_n = UDP_HDR;
      end
      UDP_HDR: begin
        byte_n = pick_byte(udp_v, cnt[4:0]);
        if (cnt == 11'(UDP_HDR_LEN - 1))
          state_n = (n_q == 16'd0) ? PAD : PAYLOAD;
      end
      PAYLOAD:
        if (cnt16 == pay_last)
          state_n = (n_q < 16'(MIN_PAYLOAD)) ? PAD
                                             : FCS;
      PAD:
        if (cnt16 == pad_last) state_n = FCS;
      FCS:
        if (cnt == 11'd3) state_n = IFG;
      IFG:
        if (cnt == 11'(IFG_CYCLES + 1))
          state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // state, byte counter, length and frame id
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      n_q   <= '0;
      id_q  <= '0;
    end else begin
      state <= state_n;
      if (state_n != state || state == IDLE)
        cnt <= '0;
      else
        cnt <= cnt + 11'd1;
      if (state == IDLE && frame_tx_start)
        n_q <= rd_byte_num;
      if (state == IFG && state_n == IDLE)
        id_q <= id_q + 16'd1;
    end
  end

  // header checksum: sum, fold, fold+invert
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      chk_q <= '0;
    end else if (state == CHKSUM) begin
      unique case (1'b1)
        (cnt == 11'd0):
          acc_q <= 32'h4500 + {16'h0, tot_len}
                 + {16'h0, id_q} + 32'h4000
                 + {16'h0, 8'h40, IP_PROTO_UDP}
                 + {16'h0, BOARD_IP[31:16]}
                 + {16'h0, BOARD_IP[15:0]}
                 + {16'h0, DES_IP[31:16]}
                 + {16'h0, DES_IP[15:0]};
        (cnt == 11'd1):
          acc_q <= {16'h0, fold};
        default:
          chk_q <= ~fold;
      endcase
    end
  end

  // registered line controls
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_en_q  <= 1'b0;
      txd_q    <= '0;
      rd_en_q  <= 1'b0;
      done_q   <= 1'b0;
      pay_q    <= 1'b0;
      fcs_q    <= 1'b0;
      crc_en_q <= 1'b0;
      fidx_q   <= '0;
    end else begin
      tx_en_q  <= state inside {PREAMBLE, ETH_HDR,
                  IP_HDR, UDP_HDR, PAYLOAD, PAD, FCS};
      txd_q    <= byte_n;
      rd_en_q  <= (state_n == PAYLOAD);
      done_q   <= (state == IFG) &&
                  (cnt == 11'(IFG_CYCLES));
      pay_q    <= (state == PAYLOAD);
      fcs_q    <= (state == FCS);
      crc_en_q <= state inside {ETH_HDR, IP_HDR,
                  UDP_HDR, PAYLOAD, PAD};
      fidx_q   <= cnt[1:0];
    end
  end

  // FCS byte select, least significant first
  always_comb begin
    unique case (fidx_q)
      2'd0:    fcs_b = crc[7:0];
      2'd1:    fcs_b = crc[15:8];
      2'd2:    fcs_b = crc[23:16];
      default: fcs_b = crc[31:24];
    endcase
  end

  assign gmii_txd = pay_q ? rd_data
                  : fcs_q ? fcs_b : txd_q;

  crc32_d8 u_crc (
    .clk   (rd_clk),
    .rst_n (rst_n),
    .clr   (state == PREAMBLE),
    .en    (crc_en_q),
    .data  (gmii_txd),
    .crc   (crc)
  );

  assign gmii_tx_en    = tx_en_q;
  assign rd_en         = rd_en_q;
  assign frame_tx_done = done_q;

endmodule

// File: tb/tb_udp_tx.sv
// tb_udp_tx: frame-level model of udp_tx
// Monitor checks every line cycle against it
module tb_udp_tx;

  logic       rd_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tx_start = 1'b0;
  logic [15:0] rd_byte_num = '0;
  logic [7:0] rd_data;
  logic       rd_en, frame_tx_done;
  logic       gmii_tx_en;
  logic [7:0] gmii_txd;

  logic       c_clr = 1'b0, c_en = 1'b0;
  logic [7:0] c_data = '0;
  logic [31:0] c_crc;

  int checks = 0;
  int errors = 0;

  always #4 rd_clk = ~rd_clk;

  udp_tx dut (
    .rd_clk         (rd_clk),
    .rst_n          (rst_n),
    .frame_tx_start (frame_tx_start),
    .rd_byte_num    (rd_byte_num),
    .rd_data        (rd_data),
    .rd_en          (rd_en),
    .frame_tx_done  (frame_tx_done),
    .gmii_tx_en     (gmii_tx_en),
    .gmii_txd       (gmii_txd)
  );

  crc32_d8 u_crc_ut (
    .clk   (rd_clk),
    .rst_n (rst_n),
    .clr   (c_clr),
    .en    (c_en),
    .data  (c_data),
    .crc   (c_crc)
  );

  // payload FIFO: data one cycle after rd_en
  logic [7:0] pay [0:2047];
  int         rptr = 0;
  logic       fifo_clr = 1'b0;
  always @(posedge rd_clk) begin
    if (fifo_clr) rptr <= 0;
    else if (rd_en) begin
      rd_data <= pay[rptr];
      rptr    <= rptr + 1;
    end
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // textbook MSB-first CRC on reflected bytes
  function automatic logic [31:0] crc_ref(input logic [7:0] q[$],
                                          input int from,
                                          input int to);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = from; i < to; i++) begin
      c = c ^ {rev8(q[i]), 24'h0};
      for (int k = 0; k < 8; k++)
        c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
    end
    return ~rev32(c);
  endfunction

  function automatic logic [15:0] ones_sum(input logic [7:0] q[$],
                                           input int from,
                                           input int words);
    logic [31:0] s;
    s = 0;
    for (int i = 0; i < words; i++)
      s = s + {16'h0, q[from+2*i], q[from+2*i+1]};
    while (s[31:16] != 0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    return s[15:0];
  endfunction

  logic [7:0] exp_q[$];
  logic [7:0] cap_q[$];
  int         exp_n = 0;

  task automatic push_be(input logic [63:0] v, input int nb);
    for (int i = nb - 1; i >= 0; i--) exp_q.push_back(v[8*i +: 8]);
  endtask

  task automatic build_frame(input int n, input logic [15:0] id);
    logic [7:0]  h[$];
    logic [15:0] ck;
    logic [31:0] c;
    exp_q.delete();
    exp_n = n;
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    push_be(64'hFFFF_FFFF_FFFF, 6);
    push_be(64'h0011_2233_4455, 6);
    push_be(64'h0800, 2);
    h.delete();
    h = '{8'h45, 8'h00, 8'((n + 28) >> 8), 8'(n + 28),
          id[15:8], id[7:0], 8'h40, 8'h00, 8'h40, 8'h11,
          8'h00, 8'h00, 8'hC0, 8'hA8, 8'h01, 8'h0A,
          8'hC0, 8'hA8, 8'h01, 8'h66};
    ck = ~ones_sum(h, 0, 10);
    h[10] = ck[15:8];
    h[11] = ck[7:0];
    foreach (h[i]) exp_q.push_back(h[i]);
    push_be(64'h04D2, 2);
    push_be(64'h04D2, 2);
    push_be(64'(16'(n + 8)), 2);
    push_be(64'h0, 2);
    for (int i = 0; i < n; i++) begin
      pay[i] = 8'(i * 13 + n + 1);
      exp_q.push_back(pay[i]);
    end
    for (int i = n; i < 18; i++) exp_q.push_back(8'h00);
    c = crc_ref(exp_q, 8, exp_q.size());
    push_be(64'({c[7:0], c[15:8], c[23:16], c[31:24]}), 4);
  endtask

  // per-cycle compare against the model frame
  initial begin
    int   pos;
    logic prev;
    pos  = 0;
    prev = 1'b0;
    forever begin
      @(negedge rd_clk);
      if (!rst_n) begin
        prev = 1'b0;
        continue;
      end
      if (gmii_tx_en && !prev) begin
        pos = 0;
        cap_q.delete();
      end
      if (!gmii_tx_en && prev)
        check("frame_len", pos, exp_q.size());
      check("rd_en", {31'h0, rd_en},
            {31'h0, gmii_tx_en && pos >= 49 && pos < 49 + exp_n});
      if (gmii_tx_en) begin
        if (pos < exp_q.size())
          check($sformatf("txd[%0d]", pos), {24'h0, gmii_txd},
                {24'h0, exp_q[pos]});
        else begin
          checks++;
          errors++;
          $display("FAIL overrun pos=%0d got=%h want=none", pos, gmii_txd);
        end
        cap_q.push_back(gmii_txd);
        pos++;
      end
      prev = gmii_tx_en;
    end
  end

  // one frame from start to done; entered and left at posedge+1
  task automatic run_frame(input int n, input logic [15:0] id,
                           input bit xtra);
    int t, len, d;
    build_frame(n, id);
    rd_byte_num    = 16'(n);
    frame_tx_start = 1'b1;
    fifo_clr       = 1'b1;
    @(posedge rd_clk); #1;
    frame_tx_start = 1'b0;
    fifo_clr       = 1'b0;
    t = 0;
    while (!gmii_tx_en && t < 10) begin
      @(posedge rd_clk); #1;
      t++;
    end
    check("start_lat", t, 4);
    len = 0;
    while (gmii_tx_en && len < 3000) begin
      len++;
      frame_tx_start = xtra && (len == 10 || len == 60);
      @(posedge rd_clk); #1;
    end
    frame_tx_start = 1'b0;
    check("tx_en_len", len, 8 + 42 + (n < 18 ? 18 : n) + 4);
    d = 1;
    while (!frame_tx_done && d < 100) begin
      @(posedge rd_clk); #1;
      d++;
    end
    check("done_lat", d, 13);
    @(posedge rd_clk); #1;
    check("done_pulse", {31'h0, frame_tx_done}, 0);
  endtask

  initial begin
    string s;
    logic [7:0] sq[$];
    int cnt;

    s = "123456789";
    for (int i = 0; i < 9; i++) sq.push_back(s[i]);
    check("model_crc", crc_ref(sq, 0, 9), 32'hCBF43926);

    repeat (3) @(posedge rd_clk);
    #1;
    check("rst_tx_en", {31'h0, gmii_tx_en}, 0);
    check("rst_txd", {24'h0, gmii_txd}, 0);
    check("rst_rd_en", {31'h0, rd_en}, 0);
    check("rst_done", {31'h0, frame_tx_done}, 0);
    rst_n = 1'b1;

    @(posedge rd_clk); #1;
    c_clr = 1'b1;
    @(posedge rd_clk); #1;
    c_clr = 1'b0;
    for (int i = 0; i < 9; i++) begin
      c_en   = 1'b1;
      c_data = s[i];
      @(posedge rd_clk); #1;
    end
    c_en = 1'b0;
    check("crc32_d8", c_crc, 32'hCBF43926);

    run_frame(1024, 16'd0, 1'b0);
    check("des_mac0", {24'h0, cap_q[8]}, 32'hFF);
    check("des_mac5", {24'h0, cap_q[13]}, 32'hFF);
    check("total_len", {16'h0, cap_q[24], cap_q[25]}, 32'h041C);
    check("ip_chk", {16'h0, cap_q[32], cap_q[33]}, 32'hB310);
    check("hdr_sum", {16'h0, ones_sum(cap_q, 22, 10)}, 32'hFFFF);
    check("udp_len", {16'h0, cap_q[46], cap_q[47]}, 32'h0408);
    check("id0", {16'h0, cap_q[26], cap_q[27]}, 0);

    run_frame(1, 16'd1, 1'b1);
    check("id1", {16'h0, cap_q[26], cap_q[27]}, 1);
    check("total_len1", {16'h0, cap_q[24], cap_q[25]}, 32'h001D);
    check("pad17", {24'h0, cap_q[67]}, 0);
    check("fcs1", {cap_q[71], cap_q[70], cap_q[69], cap_q[68]},
          crc_ref(cap_q, 8, 68));

    cnt = 0;
    repeat (30) begin
      @(posedge rd_clk); #1;
      if (gmii_tx_en) cnt++;
    end
    check("no_second_frame", cnt, 0);

    run_frame(0, 16'd2, 1'b0);
    run_frame(18, 16'd3, 1'b0);
    run_frame(17, 16'd4, 1'b0);

    build_frame(1024, 16'd5);
    rd_byte_num    = 16'd1024;
    frame_tx_start = 1'b1;
    fifo_clr       = 1'b1;
    @(posedge rd_clk); #1;
    frame_tx_start = 1'b0;
    fifo_clr       = 1'b0;
    cnt = 0;
    while (!gmii_tx_en && cnt < 10) begin
      @(posedge rd_clk); #1;
      cnt++;
    end
    check("abort_start", cnt, 4);
    repeat (500) @(posedge rd_clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_tx_en", {31'h0, gmii_tx_en}, 0);
    check("abort_txd", {24'h0, gmii_txd}, 0);
    check("abort_rd_en", {31'h0, rd_en}, 0);
    check("abort_done", {31'h0, frame_tx_done}, 0);
    repeat (5) @(posedge rd_clk);
    #1;
    rst_n = 1'b1;
    cnt = 0;
    repeat (40) begin
      @(posedge rd_clk); #1;
      if (frame_tx_done || gmii_tx_en) cnt++;
    end
    check("abort_quiet", cnt, 0);

    run_frame(20, 16'd0, 1'b0);
    check("id_after_rst", {16'h0, cap_q[26], cap_q[27]}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
